sfft_frame_scheduler: RTL and testbench

//  Sequences the SFFT pipeline. Rate-limits codec samples into it as single-cycle advance pulses.

---
 rtl/sfft_pkg.sv | 20 ++
 rtl/sfft_rate_guard.sv | 43 ++++
 rtl/sfft_frame_scheduler.sv | 136 +++++++++++++
 tb/tb_sfft_frame_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfft_pkg.sv
// Shared types and helpers for the SFFT frame scheduler.
package sfft_pkg;
  localparam int SFFT_NFFT  = 512;
  localparam int SFFT_IN_W  = 24;
  localparam int SFFT_OUT_W = 32;
  localparam int CNT_W      = 16;
  localparam int BIN_IDX_W  = $clog2(SFFT_NFFT) - 1;

  typedef logic [SFFT_OUT_W-1:0] bin_t;
  typedef logic [BIN_IDX_W-1:0]  bin_idx_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  typedef enum logic {IDLE, ARMED}   cap_state_e;
  typedef enum logic {EMPTY, STREAM} rd_state_e;

  // Saturating increment for the status counters.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (&c) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/sfft_rate_guard.sv
// Rate guard: accepts a codec sample only when at least MIN_GAP cycles have
// elapsed, registers it for the pipeline and emits a one-cycle advance pulse.
module sfft_rate_guard
  import sfft_pkg::*;
#(
  parameter int IN_W    = SFFT_IN_W,
  parameter int MIN_GAP = SFFT_NFFT / 2 + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IN_W-1:0] sample_in,
  input  logic            sample_valid,
  output logic            accept,
  output logic [IN_W-1:0] sfft_sample,
  output logic            sfft_advance,
  output cnt_t            drop_cnt
);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);

  logic [GAP_W-1:0] gap;

  assign accept = sample_valid && (gap >= GAP_MAX);

  // Gap counter saturates at MIN_GAP so the first sample after idle is always taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap          <= GAP_MAX;
      sfft_sample  <= '0;
      sfft_advance <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      sfft_advance <= accept;
      if (accept) begin
        gap         <= '0;
        sfft_sample <= sample_in;
      end else begin
        if (gap < GAP_MAX) gap <= gap + 1'b1;
        if (sample_valid)  drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end
endmodule

// File: rtl/sfft_frame_scheduler.sv
// SFFT frame scheduler: rate-limits samples into the pipeline, captures one
// FFT result every HOP accepted samples into a double buffer and streams the
// lower NFFT/2 real bins out over a valid/ready port.
// Optional build macro SFFT_SCHED_ABS_EN: bins are stored as saturated |bin|.
module sfft_frame_scheduler
  import sfft_pkg::*;
#(
  parameter int NFFT    = SFFT_NFFT,
  parameter int IN_W    = SFFT_IN_W,
  parameter int OUT_W   = SFFT_OUT_W,
  parameter int HOP     = 128,
  parameter int MIN_GAP = NFFT / 2 + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_W-1:0]            sample_in,
  input  logic                       sample_valid,
  output logic [IN_W-1:0]            sfft_sample,
  output logic                       sfft_advance,
  input  logic [NFFT-1:0][OUT_W-1:0] sfft_bins,
  input  logic                       sfft_out_valid,
  output logic [OUT_W-1:0]           bin_data,
  output logic [$clog2(NFFT)-2:0]    bin_index,
  output logic                       bin_valid,
  output logic                       bin_last,
  input  logic                       bin_ready,
  output logic [CNT_W-1:0]           frame_id,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [CNT_W-1:0]           overrun_cnt
);
  localparam int HALF  = NFFT / 2;
  localparam int IDX_W = $clog2(NFFT) - 1;
  localparam int HOP_W = (HOP > 1) ? $clog2(HOP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF - 1);
  localparam logic [HOP_W-1:0] HOP_LAST = HOP_W'(HOP - 1);

  cap_state_e       cap_state, cap_next;
  rd_state_e        rd_state, rd_next;
  logic [HOP_W-1:0] hop_cnt;
  logic             cap_full;
  logic             accept, last_hs, xfer, cap_take, cap_lost;
  logic [OUT_W-1:0] cap_bank [HALF];
  logic [OUT_W-1:0] rd_bank  [HALF];
  logic             unused_hi;

  // Only the non-redundant half of the spectrum is streamed.
  assign unused_hi = ^sfft_bins[NFFT-1:HALF];

  // Stored bin value: raw, or magnitude with the most-negative code clamped.
  function automatic logic [OUT_W-1:0] conv(input logic [OUT_W-1:0] b);
`ifdef SFFT_SCHED_ABS_EN
    if (!b[OUT_W-1]) return b;
    if (b == {1'b1, {(OUT_W-1){1'b0}}}) return {1'b0, {(OUT_W-1){1'b1}}};
    return -b;
`else
    return b;
`endif
  endfunction

  sfft_rate_guard #(.IN_W(IN_W), .MIN_GAP(MIN_GAP)) u_guard (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .accept       (accept),
    .sfft_sample  (sfft_sample),
    .sfft_advance (sfft_advance),
    .drop_cnt     (drop_cnt)
  );

  assign bin_valid = (rd_state == STREAM);
  assign bin_last  = bin_valid && (bin_index == LAST_IDX);
  assign bin_data  = bin_valid ? rd_bank[bin_index] : '0;

  // Next-state for capture and read FSMs; a finishing stream frees cap_bank
  // in the same cycle so a coincident capture is not an overrun.
  always_comb begin
    last_hs  = bin_valid && bin_ready && bin_last;
    xfer     = cap_full && ((rd_state == EMPTY) || last_hs);
    cap_take = 1'b0;
    cap_lost = 1'b0;
    cap_next = cap_state;
    rd_next  = rd_state;
    case (cap_state)
      IDLE:    if (accept && hop_cnt == HOP_LAST) cap_next = ARMED;
      ARMED:   if (sfft_out_valid) begin
                 cap_next = IDLE;
                 cap_take = !cap_full || xfer;
                 cap_lost = cap_full && !xfer;
               end
      default: cap_next = IDLE;
    endcase
    case (rd_state)
      EMPTY:   if (xfer) rd_next = STREAM;
      STREAM:  if (last_hs && !xfer) rd_next = EMPTY;
      default: rd_next = EMPTY;
    endcase
  end

  // State registers, hop counter, bank flags and stream bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_state   <= IDLE;
      rd_state    <= EMPTY;
      hop_cnt     <= '0;
      cap_full    <= 1'b0;
      bin_index   <= '0;
      frame_id    <= '0;
      overrun_cnt <= '0;
    end else begin
      cap_state <= cap_next;
      rd_state  <= rd_next;
      cap_full  <= cap_take || (cap_full && !xfer);
      if (cap_state == IDLE && accept)
        hop_cnt <= (hop_cnt == HOP_LAST) ? '0 : hop_cnt + 1'b1;
      if (xfer) begin
        bin_index <= '0;
        frame_id  <= frame_id + 1'b1;
      end else if (bin_valid && bin_ready && !bin_last) begin
        bin_index <= bin_index + 1'b1;
      end
      if (cap_lost) overrun_cnt <= sat_inc(overrun_cnt);
    end
  end

  // Capture bank: latches the lower half of the FFT output.
  always_ff @(posedge clk) begin
    if (cap_take)
      for (int k = 0; k < HALF; k++) cap_bank[k] <= conv(sfft_bins[k]);
  end

  // Read bank: whole-frame copy on transfer.
  always_ff @(posedge clk) begin
    if (xfer) rd_bank <= cap_bank;
  end
endmodule

// File: tb/tb_sfft_frame_scheduler.sv
// Bench for sfft_frame_scheduler: directed scenarios plus a randomized phase,
// all checked every cycle against a frame-level reference model.
module tb_sfft_frame_scheduler;
  localparam int NFFT    = 512;
  localparam int IN_W    = 24;
  localparam int OUT_W   = 32;
  localparam int HOP     = 4;
  localparam int HALF    = NFFT / 2;
  localparam int MIN_GAP = HALF + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [IN_W-1:0] sample_in = '0;
  logic sample_valid = 1'b0;
  logic [IN_W-1:0] sfft_sample;
  logic sfft_advance;
  logic [NFFT-1:0][OUT_W-1:0] sfft_bins;
  logic sfft_out_valid = 1'b0;
  logic [OUT_W-1:0] bin_data;
  logic [7:0] bin_index;
  logic bin_valid, bin_last;
  logic bin_ready = 1'b1;
  logic [15:0] frame_id, drop_cnt, overrun_cnt;

  int total = 0;
  int bad = 0;
  int adv_seen = 0;

  always #5 clk = ~clk;

  sfft_frame_scheduler #(.NFFT(NFFT), .IN_W(IN_W), .OUT_W(OUT_W), .HOP(HOP), .MIN_GAP(MIN_GAP)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sfft_sample(sfft_sample), .sfft_advance(sfft_advance), .sfft_bins(sfft_bins),
    .sfft_out_valid(sfft_out_valid), .bin_data(bin_data), .bin_index(bin_index),
    .bin_valid(bin_valid), .bin_last(bin_last), .bin_ready(bin_ready),
    .frame_id(frame_id), .drop_cnt(drop_cnt), .overrun_cnt(overrun_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_gap, m_hop, m_idx;
  bit          m_armed, m_full, m_str, m_adv;
  logic [15:0] m_fid, m_drop, m_ovr;
  logic [IN_W-1:0] m_sample;
  logic [31:0] m_cap [HALF];
  logic [31:0] m_rd  [HALF];

  function automatic logic [31:0] mconv(input logic [31:0] b);
`ifdef SFFT_SCHED_ABS_EN
    longint v;
    v = longint'($signed(b));
    if (v < 0) v = -v;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    return v[31:0];
`else
    return b;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_gap = MIN_GAP; m_hop = 0; m_idx = 0;
      m_armed = 0; m_full = 0; m_str = 0; m_adv = 0;
      m_fid = 0; m_drop = 0; m_ovr = 0; m_sample = 0;
    end else begin
      bit acc, hs, hs_last, xfer, got, lost;
      acc     = sample_valid && (m_gap >= MIN_GAP);
      hs      = m_str && bin_ready;
      hs_last = hs && (m_idx == HALF - 1);
      xfer    = m_full && (!m_str || hs_last);
      got     = m_armed && sfft_out_valid && (!m_full || xfer);
      lost    = m_armed && sfft_out_valid && m_full && !xfer;
      // sample path
      m_adv = acc;
      if (acc) begin m_sample = sample_in; m_gap = 0; end
      else begin
        if (m_gap < MIN_GAP) m_gap++;
        if (sample_valid && m_drop != 16'hFFFF) m_drop++;
      end
      // read side
      if (xfer) begin m_rd = m_cap; m_str = 1; m_idx = 0; m_fid++; end
      else if (hs_last) m_str = 0;
      else if (hs) m_idx++;
      // capture side
      m_full = (m_full && !xfer) || got;
      if (got) for (int k = 0; k < HALF; k++) m_cap[k] = mconv(sfft_bins[k]);
      if (lost && m_ovr != 16'hFFFF) m_ovr++;
      if (m_armed) begin
        if (sfft_out_valid) m_armed = 0;
      end else if (acc) begin
        if (m_hop == HOP - 1) begin m_hop = 0; m_armed = 1; end
        else m_hop++;
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("bin_valid", bin_valid, m_str);
    chk("bin_last", bin_last, m_str && m_idx == HALF - 1);
    if (m_str) begin
      chk("bin_index", bin_index, m_idx);
      chk("bin_data", bin_data, m_rd[m_idx]);
    end
    chk("frame_id", frame_id, m_fid);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("overrun_cnt", overrun_cnt, m_ovr);
    chk("sfft_advance", sfft_advance, m_adv);
    chk("sfft_sample", sfft_sample, m_sample);
    if (sfft_advance) adv_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) cyc(); endtask
  task automatic send(input logic [IN_W-1:0] v);
    sample_in = v; sample_valid = 1'b1; cyc(); sample_valid = 1'b0;
  endtask
  task automatic fire(); sfft_out_valid = 1'b1; cyc(); sfft_out_valid = 1'b0; endtask
  task automatic wait_valid(input string nm, input int budget, output int n);
    n = 0;
    while (!bin_valid && n < budget) begin cyc(); n++; end
    chk(nm, bin_valid, 1'b1);
  endtask
  task automatic pulse_reset(); reset = 1'b1; cyc(); reset = 1'b0; idle(2); endtask
  task automatic hop_samples(); // HOP samples spaced exactly at the accept boundary
    for (int i = 0; i < HOP; i++) begin send(IN_W'($urandom)); idle(MIN_GAP); end
  endtask
  task automatic rand_bins();
    for (int k = 0; k < NFFT; k++)
      sfft_bins[k] = ($urandom_range(15) == 0) ? 32'h8000_0000 : $urandom;
  endtask
  task automatic rcyc(input int pct);
    bin_ready = ($urandom_range(99) < pct);
    if ($urandom_range(79) == 0) begin rand_bins(); sfft_out_valid = 1'b1; end
    cyc();
    sfft_out_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] e0, e255;
    for (int k = 0; k < NFFT; k++) sfft_bins[k] = OUT_W'(k * 3 - 100);
    idle(3);
    chk("rst_bin_valid", bin_valid, 1'b0);
    chk("rst_frame_id", frame_id, 16'd0);
    chk("rst_sfft_sample", sfft_sample, 24'd0);
    reset = 1'b0;
    idle(2);

    // samples every 300 cycles: all accepted
    for (int i = 0; i < HOP; i++) begin send(IN_W'(24'h100 + i)); idle(299); end
    chk("t1_drop", drop_cnt, 16'd0);
    chk("t1_adv_pulses", adv_seen, 4);

    // armed after 4th sample: ramp frame streams
`ifdef SFFT_SCHED_ABS_EN
    e0 = 32'd100;
`else
    e0 = 32'hFFFF_FF9C;
`endif
    e255 = 32'd665;
    fire();
    wait_valid("t3_valid", 5, n);
    chk("t3_latency", n, 1);
    chk("t3_idx0", bin_index, 8'd0);
    chk("t3_data0", bin_data, e0);
    chk("t3_fid", frame_id, 16'd1);
    n = 0;
    while (!bin_last && n < 300) begin cyc(); n++; end
    chk("t3_last_idx", bin_index, 8'd255);
    chk("t3_last_data", bin_data, e255);
    cyc();

    // two samples 10 cycles apart: second dropped
    send(24'hABCDE); idle(9); send(24'h12345); idle(2);
    chk("t2_drop", drop_cnt, 16'd1);
    chk("t2_sample", sfft_sample, 24'hABCDE);

    // stalled consumer across three captures
    pulse_reset();
    bin_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin hop_samples(); rand_bins(); fire(); idle(3); end
    chk("t4_overrun", overrun_cnt, 16'd1);
    chk("t4_fid_stalled", frame_id, 16'd1);
    chk("t4_idx_stalled", bin_index, 8'd0);
    bin_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * HALF; i++) begin if (bin_valid) n++; cyc(); end
    chk("t4_back_to_back", n, 2 * HALF);
    chk("t4_fid_end", frame_id, 16'd2);
    chk("t4_drained", bin_valid, 1'b0);

    // reset in the middle of a stream
    hop_samples(); fire();
    wait_valid("t5_valid", 5, n);
    n = 0;
    while (bin_index != 8'd37 && n < 60) begin cyc(); n++; end
    chk("t5_at37", bin_index, 8'd37);
    reset = 1'b1; #1;
    chk("t5_valid_drop", bin_valid, 1'b0);
    cyc(); reset = 1'b0; idle(1);
    chk("t5_fid0", frame_id, 16'd0);
    chk("t5_ovr0", overrun_cnt, 16'd0);
    chk("t5_drop0", drop_cnt, 16'd0);
    hop_samples(); fire();
    wait_valid("t5_revalid", 5, n);
    chk("t5_fid1", frame_id, 16'd1);
    chk("t5_idx0", bin_index, 8'd0);

    // randomized traffic
    for (int ev = 0; ev < 55; ev++) begin
      int gap, pct;
      case ($urandom_range(5))
        0: gap = $urandom_range(20);
        1: gap = MIN_GAP - 1;
        2: gap = MIN_GAP;
        3: gap = MIN_GAP + 1;
        default: gap = $urandom_range(300);
      endcase
      case ($urandom_range(2))
        0: pct = 10;
        1: pct = 75;
        default: pct = 100;
      endcase
      sample_in = IN_W'($urandom); sample_valid = 1'b1;
      rcyc(pct);
      sample_valid = 1'b0;
      repeat (gap) rcyc(pct);
    end
    bin_ready = 1'b1;
    idle(600);

`ifdef SFFT_SCHED_ABS_EN
    pulse_reset();
    sfft_bins[0] = 32'h8000_0000;
    sfft_bins[1] = 32'hFFFF_FFFB;
    hop_samples(); fire();
    wait_valid("t6_valid", 5, n);
    chk("t6_abs_min", bin_data, 32'h7FFF_FFFF);
    cyc();
    chk("t6_abs_m5", bin_data, 32'd5);
    idle(300);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
